// File: rtl/srsc_pkg.sv
// Shared constants and helpers for the SRSC saturation-correction datapath.
// Holds default Q-formats, user sideband bit positions and fixed-point helpers.
package srsc_pkg;

    localparam int X1_FRAC_DEF = 13;
    localparam int X2_FRAC_DEF = 10;
    localparam int PIX_W       = 8;

    localparam int USER_SOF = 0;
    localparam int USER_EOL = 1;

    function automatic int frac_sum(input int x1_frac, input int x2_frac);
        return x1_frac + x2_frac;
    endfunction

    // Half an output LSB at the product's binary point; zero when truncating.
    function automatic logic [63:0] round_const(input int f, input int round_en);
        if (round_en != 0 && f >= 1) begin
            return 64'd1 << (f - 1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/sc_round_clamp.sv
// Combinational per-channel round, shift and clamp of one full-width product.
// The sum is one bit wider than the product so the rounding add cannot wrap.
module sc_round_clamp
    import srsc_pkg::*;
#(
    parameter int PW    = 32,
    parameter int F     = 23,
    parameter int OUT_W = 8,
    parameter int ROUND = 1
) (
    input  logic [PW-1:0]    p_i,
    output logic [OUT_W-1:0] value_o,
    output logic             sat_o
);

    localparam logic [PW:0] RC = (PW + 1)'(round_const(F, ROUND));

    logic [PW:0] r;
    logic [PW:0] q;

    assign r       = {1'b0, p_i} + RC;
    assign q       = r >> F;
    assign sat_o   = |q[PW:OUT_W];
    assign value_o = sat_o ? '1 : q[OUT_W-1:0];

endmodule

// File: rtl/saturation_correction_mult_pipe.sv
// Per-channel Ac^b * Jc^(1-b) multiplier: 3-stage valid/ready pipeline with
// round/clamp, sideband passthrough and a saturating clamp-event counter.
module saturation_correction_mult_pipe
    import srsc_pkg::*;
#(
    parameter int CH      = 3,
    parameter int X1_W    = 16,
    parameter int X1_FRAC = X1_FRAC_DEF,
    parameter int X2_W    = 16,
    parameter int X2_FRAC = X2_FRAC_DEF,
    parameter int OUT_W   = PIX_W,
    parameter int ROUND   = 1,
    parameter int USER_W  = 2,
    parameter int CNT_W   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*X1_W-1:0]    x1,
    input  logic [CH*X2_W-1:0]    x2,
    input  logic [USER_W-1:0]     in_user,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   result,
    output logic [USER_W-1:0]     out_user,
    output logic [CH-1:0]         sat_flag,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      sat_cnt
);

    localparam int PW = X1_W + X2_W;
    localparam int F  = frac_sum(X1_FRAC, X2_FRAC);

    generate
        if ((ROUND != 0 && F < 1) || (PW + 1 - F < OUT_W)) begin : g_bad_cfg
            $error("saturation_correction_mult_pipe: invalid operand/result format");
        end
    endgenerate

    logic                   v1_q, v2_q, v3_q;
    logic [CH*X1_W-1:0]     x1_q;
    logic [CH*X2_W-1:0]     x2_q;
    logic [CH-1:0][PW-1:0]  p2_q;
    logic [USER_W-1:0]      u1_q, u2_q, u3_q;
    logic [CH*OUT_W-1:0]    result_q;
    logic [CH-1:0]          sat_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH*OUT_W-1:0]    rc_val;
    logic [CH-1:0]          rc_sat;
    logic                   stall;

    // Handshake: a beat moves in on in_valid & in_ready and out on
    // out_valid & out_ready. The only stall source is an unaccepted output
    // beat; it freezes every stage at once, so in_ready is simply ~stall and
    // bubbles elsewhere in the pipe never block upstream progress.
    assign stall     = v3_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3_q;
    assign result    = result_q;
    assign out_user  = u3_q;
    assign sat_flag  = sat_q;
    assign sat_cnt   = cnt_q;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sc_round_clamp #(
            .PW    (PW),
            .F     (F),
            .OUT_W (OUT_W),
            .ROUND (ROUND)
        ) u_rc (
            .p_i     (p2_q[c]),
            .value_o (rc_val[c*OUT_W +: OUT_W]),
            .sat_o   (rc_sat[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            p2_q     <= '0;
            u1_q     <= '0;
            u2_q     <= '0;
            u3_q     <= '0;
            result_q <= '0;
            sat_q    <= '0;
        end else if (!stall) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                x1_q <= x1;
                x2_q <= x2;
                u1_q <= in_user;
            end
            if (v1_q) begin
                for (int c = 0; c < CH; c++) begin
                    p2_q[c] <= PW'(x1_q[c*X1_W +: X1_W]) * PW'(x2_q[c*X2_W +: X2_W]);
                end
                u2_q <= u1_q;
            end
            if (v2_q) begin
                result_q <= rc_val;
                sat_q    <= rc_sat;
                u3_q     <= u2_q;
            end
        end
    end

    // Clear beats a same-cycle increment; the count sticks at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (v3_q && out_ready && (|sat_q) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_saturation_correction_mult_pipe.sv
// Directed bench for saturation_correction_mult_pipe: default, truncating and
// widened-format instances share the clock and handshake controls.
module tb_saturation_correction_mult_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_cnt   = 1'b0;
    logic [47:0] x1        = '0;
    logic [47:0] x2        = '0;
    logic [1:0]  in_user   = '0;
    logic [15:0] sw_x1     = '0;
    logic [17:0] sw_x2     = '0;

    logic        in_ready, out_valid;
    logic [23:0] result;
    logic [1:0]  out_user;
    logic [2:0]  sat_flag;
    logic [23:0] sat_cnt;

    logic        tr_in_ready, tr_out_valid;
    logic [23:0] tr_result;
    logic [1:0]  tr_out_user;
    logic [2:0]  tr_sat_flag;
    logic [23:0] tr_sat_cnt;

    logic        sw_in_ready, sw_out_valid;
    logic [9:0]  sw_result;
    logic [1:0]  sw_out_user;
    logic [0:0]  sw_sat_flag;
    logic [23:0] sw_sat_cnt;

    int total = 0;
    int bad   = 0;

    saturation_correction_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .in_user(in_user), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_user(out_user),
        .sat_flag(sat_flag), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
    );

    saturation_correction_mult_pipe #(.ROUND(0)) dut_tr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(tr_in_ready),
        .x1(x1), .x2(x2), .in_user(in_user), .out_valid(tr_out_valid),
        .out_ready(out_ready), .result(tr_result), .out_user(tr_out_user),
        .sat_flag(tr_sat_flag), .clr_cnt(clr_cnt), .sat_cnt(tr_sat_cnt)
    );

    saturation_correction_mult_pipe #(.CH(1), .OUT_W(10), .X2_FRAC(8), .X2_W(18)) dut_sw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_in_ready),
        .x1(sw_x1), .x2(sw_x2), .in_user(in_user), .out_valid(sw_out_valid),
        .out_ready(out_ready), .result(sw_result), .out_user(sw_out_user),
        .sat_flag(sw_sat_flag), .clr_cnt(clr_cnt), .sat_cnt(sw_sat_cnt)
    );

    function automatic logic [47:0] rep16(input logic [15:0] v);
        return {v, v, v};
    endfunction

    function automatic logic [23:0] rep8(input logic [7:0] v);
        return {v, v, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [47:0] a, input logic [47:0] b, input logic [1:0] u,
                              input logic [15:0] sa, input logic [17:0] sb);
        x1 = a; x2 = b; in_user = u; sw_x1 = sa; sw_x2 = sb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the acceptance cycle until out_valid; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (result !== 24'h0) begin bad++; $display("FAIL reset_result: got %h want 000000", result); end
        total++; if (out_user !== 2'b00) begin bad++; $display("FAIL reset_out_user: got %b want 00", out_user); end
        total++; if (sat_flag !== 3'b000) begin bad++; $display("FAIL reset_sat_flag: got %b want 000", sat_flag); end
        total++; if (sat_cnt !== 24'd0) begin bad++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tick();
    endtask

    task automatic test_latency();
        int lat;
        drive_beat(rep16(16'd32768), rep16(16'd51200), 2'b01, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (lat != 3) begin bad++; $display("FAIL latency: got %0d want 3", lat); end
        total++; if (result !== rep8(8'd200)) begin bad++; $display("FAIL latency_result: got %h want c8c8c8", result); end
        total++; if (sat_flag !== 3'b000) begin bad++; $display("FAIL latency_sat_flag: got %b want 000", sat_flag); end
        total++; if (out_user !== 2'b01) begin bad++; $display("FAIL latency_user: got %b want 01", out_user); end
        total++; if (sat_cnt !== 24'd0) begin bad++; $display("FAIL latency_sat_cnt: got %0d want 0", sat_cnt); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_single_beat: got %0b want 0", out_valid); end
    endtask

    task automatic test_rounding();
        int lat;
        drive_beat(rep16(16'd8192), rep16(16'd1536), 2'b00, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (lat != 3) begin bad++; $display("FAIL round_latency: got %0d want 3", lat); end
        total++; if (result !== rep8(8'd2)) begin bad++; $display("FAIL round_half_up: got %h want 020202", result); end
        total++; if (tr_out_valid !== 1'b1 || tr_result !== rep8(8'd1)) begin
            bad++; $display("FAIL round_truncate: got valid=%0b %h want valid=1 010101", tr_out_valid, tr_result);
        end
        tick();
        drive_beat(rep16(16'd8192), rep16(16'd1535), 2'b00, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (result !== rep8(8'd1)) begin bad++; $display("FAIL round_below_half: got %h want 010101", result); end
        tick();
    endtask

    task automatic test_clamp();
        int lat;
        drive_beat({16'd8192, 16'd8192, 16'hFFFF}, {16'd10240, 16'd10240, 16'hFFFF}, 2'b00, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (result !== {8'd10, 8'd10, 8'd255}) begin bad++; $display("FAIL clamp_result: got %h want 0a0aff", result); end
        total++; if (sat_flag !== 3'b001) begin bad++; $display("FAIL clamp_sat_flag: got %b want 001", sat_flag); end
        total++; if (sat_cnt !== 24'd0) begin bad++; $display("FAIL clamp_cnt_before: got %0d want 0", sat_cnt); end
        tick();
        total++; if (sat_cnt !== 24'd1) begin bad++; $display("FAIL clamp_cnt_inc: got %0d want 1", sat_cnt); end
        drive_beat({16'd8192, 16'd8192, 16'hFFFF}, {16'd10240, 16'd10240, 16'hFFFF}, 2'b00, 16'd0, 18'd0);
        wait_out(lat);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (sat_cnt !== 24'd0) begin bad++; $display("FAIL clamp_clr_priority: got %0d want 0", sat_cnt); end
    endtask

    task automatic test_zero_max();
        int lat;
        drive_beat(48'h0, 48'h0, 2'b00, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (result !== 24'h0 || sat_flag !== 3'b000) begin
            bad++; $display("FAIL zero_operands: got %h flag %b want 000000 flag 000", result, sat_flag);
        end
        tick();
        drive_beat({48{1'b1}}, {48{1'b1}}, 2'b00, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (result !== rep8(8'd255) || sat_flag !== 3'b111) begin
            bad++; $display("FAIL max_operands: got %h flag %b want ffffff flag 111", result, sat_flag);
        end
        tick();
        total++; if (sat_cnt !== 24'd1) begin bad++; $display("FAIL max_cnt: got %0d want 1", sat_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [25:0] exp_q[$];
        int n_out = 0;
        int stall_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] r8;
            logic [1:0] u2;
            r8 = 8'(i + 1);
            u2 = 2'(i);
            exp_q.push_back({u2, rep8(r8)});
        end
        fork
            begin : drv
                for (int i = 0; i < 10; i++) begin
                    logic acc;
                    int guard;
                    x1 = rep16(16'd8192);
                    x2 = rep16(16'((i + 1) * 1024));
                    in_user = 2'(i);
                    in_valid = 1'b1;
                    acc = 1'b0;
                    guard = 0;
                    while (!acc && guard < 30) begin
                        @(posedge clk);
                        acc = in_ready;
                        #1;
                        guard++;
                    end
                end
                in_valid = 1'b0;
            end
            begin : rdy
                repeat (5) tick();
                out_ready = 1'b0;
                repeat (4) tick();
                out_ready = 1'b1;
            end
            begin : mon
                logic        prev_stall = 1'b0;
                logic [23:0] prev_res = '0;
                logic [1:0]  prev_user = '0;
                int          cyc = 0;
                while (n_out < 10 && cyc < 60) begin
                    logic stall_now;
                    @(posedge clk);
                    cyc++;
                    stall_now = out_valid & ~out_ready;
                    if (stall_now) stall_cycles++;
                    total++; if (in_ready !== ~stall_now) begin
                        bad++; $display("FAIL bp_in_ready: got %0b want %0b cycle %0d", in_ready, ~stall_now, cyc);
                    end
                    if (prev_stall) begin
                        total++; if (result !== prev_res || out_user !== prev_user) begin
                            bad++; $display("FAIL bp_hold: got %h/%b want %h/%b", result, out_user, prev_res, prev_user);
                        end
                    end
                    if (out_valid && out_ready) begin
                        n_out++;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++; $display("FAIL bp_extra_beat: got %h/%b want none", result, out_user);
                        end else begin
                            logic [25:0] e;
                            e = exp_q.pop_front();
                            if ({out_user, result} !== e) begin
                                bad++; $display("FAIL bp_beat: got %b/%h want %b/%h", out_user, result, e[25:24], e[23:0]);
                            end
                        end
                    end
                    prev_stall = stall_now;
                    prev_res = result;
                    prev_user = out_user;
                end
            end
        join
        #1;
        total++; if (n_out != 10 || exp_q.size() != 0) begin
            bad++; $display("FAIL bp_count: got %0d beats, %0d left want 10, 0", n_out, exp_q.size());
        end
        total++; if (stall_cycles != 4) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 4", stall_cycles); end
        tick();
    endtask

    task automatic test_async_reset();
        int lat;
        x1 = rep16(16'd8192); x2 = rep16(16'd2048); in_user = 2'b11;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || sat_cnt !== 24'd1) begin
            bad++; $display("FAIL areset_pre: got valid=%0b cnt=%0d want valid=1 cnt=1", out_valid, sat_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %0b want 0", out_valid); end
        total++; if (result !== 24'h0 || out_user !== 2'b00) begin
            bad++; $display("FAIL areset_data: got %h/%b want 000000/00", result, out_user);
        end
        total++; if (sat_cnt !== 24'd0) begin bad++; $display("FAIL areset_sat_cnt: got %0d want 0", sat_cnt); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_stale: got %0b want 0", out_valid); end
        drive_beat(rep16(16'd8192), rep16(16'd5120), 2'b10, 16'd0, 18'd0);
        wait_out(lat);
        total++; if (lat != 3) begin bad++; $display("FAIL areset_latency: got %0d want 3", lat); end
        total++; if (result !== rep8(8'd5) || out_user !== 2'b10) begin
            bad++; $display("FAIL areset_new_beat: got %h/%b want 050505/10", result, out_user);
        end
        tick();
    endtask

    task automatic test_sweep();
        int lat;
        drive_beat(48'h0, 48'h0, 2'b00, 16'd8192, 18'd179200);
        wait_out(lat);
        total++; if (sw_out_valid !== 1'b1 || sw_result !== 10'd700 || sw_sat_flag !== 1'b0) begin
            bad++; $display("FAIL sweep_700: got valid=%0b %0d flag %b want valid=1 700 flag 0", sw_out_valid, sw_result, sw_sat_flag);
        end
        tick();
        drive_beat(48'h0, 48'h0, 2'b00, 16'd8192, 18'd65535);
        wait_out(lat);
        total++; if (sw_result !== 10'd256 || sw_sat_flag !== 1'b0) begin
            bad++; $display("FAIL sweep_256: got %0d flag %b want 256 flag 0", sw_result, sw_sat_flag);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_clamp();
        test_zero_max();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/saturation_correction_mult_pipe.md
Name: saturation_correction_mult_pipe

Overview:
- Per-channel fixed-point multiplier for the SRSC saturation-correction stage. Computes Ac^β · Jc^(1-β) for CH colour channels in parallel.
- Parametrised operand formats, round-half-up, clamps to OUT_W bits, and reports saturation.
- Sits between the power-function units and the output pixel packer.
- Uses a 3-stage valid/ready pipeline with sideband passthrough and a sticky saturation counter.

Parameters:
- CH, 3: number of colour channels processed in lockstep.
- X1_W, 16: width of operand x1 per channel (unsigned).
- X1_FRAC, 13: fractional bits of x1 (default Q3.13).
- X2_W, 16: width of operand x2 per channel (unsigned).
- X2_FRAC, 10: fractional bits of x2 (default Q6.10).
- OUT_W, 8: integer result width per channel (unsigned).
- ROUND, 1: 1 = round half up, 0 = truncate.
- USER_W, 2: sideband width (e.g. {sof, eol}), passed through with data.
- CNT_W, 24: width of the saturation event counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0; deassertion assumed synchronised upstream).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x1  in  CH*X1_W  packed operand 1; channel c at [c*X1_W +: X1_W].
- x2  in  CH*X2_W  packed operand 2, same packing.
- in_user  in  USER_W  sideband travelling with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- result  out  CH*OUT_W  packed clamped results.
- out_user  out  USER_W  sideband aligned with result.
- sat_flag  out  CH  per-channel flag: that channel was clamped in this beat.
- clr_cnt  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  count of output beats with any sat_flag bit set.

Behaviour:
- Reset (rst=0, async): all stage valids 0, all data/user registers 0, sat_cnt 0. Outputs read out_valid=0, result=0, out_user=0, sat_flag=0. in_ready=1 once rst=1.
- Reset mid-stream discards all in-flight beats; nothing is replayed.
- Pipeline:
  - S1 registers operands and user.
  - S2 registers the full products, width PW=X1_W+X2_W, per channel.
  - S3 applies round, shift and clamp, and registers result, sat_flag and user.
- Latency: exactly 3 cycles from an accepted input beat to out_valid, with out_ready held at 1.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready. While stalled every stage holds; in_ready = ~stall, combinational.
  - With out_ready held at 1, throughput is 1 beat/cycle.
  - Bubbles propagate: a stage with valid=0 advances even if downstream is empty.
- Out beat stability: while out_valid=1 and out_ready=0, result, out_user and sat_flag are held unchanged.
- Arithmetic, per channel:
  - F = X1_FRAC + X2_FRAC.
  - p = x1*x2, unsigned, PW bits.
  - If ROUND=1, r = p + 2^(F-1), computed PW+1 bits wide so it cannot wrap. Otherwise r = p.
  - q = r >> F.
  - If q > 2^OUT_W - 1, result = all ones and sat_flag = 1; else result = q[OUT_W-1:0] and sat_flag = 0.
- Constraint (elaboration-time check): F ≥ 1 when ROUND=1, and PW+1-F ≥ OUT_W.
- sat_cnt:
  - Increments by 1 on each output transfer where |sat_flag.
  - Saturates at all ones; never wraps.
  - clr_cnt has priority over a same-cycle increment; the result is 0.
- Zero operands give result 0 with no flag.
- Max operands (all ones) at defaults give result 255 with sat_flag set.

Decomposition:
- Shared package srsc_pkg holds:
  - default Q-format constants: X1_FRAC=13, X2_FRAC=10, PIX_W=8;
  - a function computing F and the rounding constant;
  - the user-field bit positions SOF=0 and EOL=1.
- One natural sub-module: sc_round_clamp, the combinational per-channel round/shift/clamp (params PW, F, OUT_W, ROUND; outputs value and sat). It is instantiated CH times in S3.
- Top level holds the pipeline valid/stall control and the counter.

Test Plan:
- Reset and latency. rst low, then high. Drive one beat with x1=32768 (4.0) and x2=51200 (50.0) on all channels, out_ready=1.
  -> out_valid exactly 3 cycles after acceptance; result=200 on each channel; sat_flag=0; sat_cnt=0.
- Rounding. x1=8192 (1.0), x2=1536 (1.5).
  -> ROUND=1 gives 2; ROUND=0 build gives 1. Also x2=1535 gives 1 with ROUND=1.
- Clamping. ch0 x1=x2=65535; ch1 and ch2 x1=8192, x2=10240.
  -> result = {10, 10, 255}; sat_flag=3'b001; sat_cnt goes 0→1. A second such beat with clr_cnt pulsed in the same cycle -> sat_cnt=0.
- Backpressure. Stream 10 beats back-to-back with incrementing x2 and in_user; hold out_ready=0 for 4 cycles mid-stream.
  -> in_ready drops the same cycle stall asserts; result is held stable; no beat is lost or duplicated; out_user stays aligned.
- Async reset mid-stream. Assert rst=0 between clock edges with 3 beats in flight.
  -> out_valid=0, result=0 and sat_cnt=0 immediately, without a clock edge. After release the first new beat emerges 3 cycles after acceptance with no stale data.
- Parameter sweep. CH=1, OUT_W=10, X2_FRAC=8 with x1=8192 (1.0), x2=256*700 (700.0).
  -> result=700, no flag. x2=65535 -> 256, no flag.
